vga_timing_gen: RTL and testbench

- Generates 640x480@60 VGA raster timing from the 25.175 MHz pixel clock: hcount, vcount, hsync, vsync and active_video.
- Drives the memory controller's timing inputs and the VGA connector sync pins.
- Adds frame_start, vblank_start and frame_count so the reel animation can step once per frame and swap state during blanking.

---
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 87 ++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (memory controller, sync pins, reel animation).
interface vga_timing_gen_if;
  logic        pix_en;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        active_video;
  logic        frame_start;
  logic        vblank_start;
  logic [15:0] frame_count;

  modport master (
    input  pix_en,
    output hcount, vcount, hsync, vsync, active_video,
    output frame_start, vblank_start, frame_count
  );

  modport slave (
    output pix_en,
    input  hcount, vcount, hsync, vsync, active_video,
    input  frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: registered counts, syncs, active video and
// per-frame markers, all decoded from the next-state counts for zero skew.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic        h_wrap;
  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        active_nxt;
  logic        at_origin;
  logic        at_vblank;

  always_comb begin
    // Out-of-range counts are treated as the end of their range so they
    // recover to 0 on the next advance.
    h_wrap = (vga.hcount == H_LAST) || (vga.hcount > H_LAST);
    h_nxt  = h_wrap ? '0 : vga.hcount + 11'd1;

    if (vga.vcount > V_LAST)
      v_nxt = '0;
    else if (h_wrap)
      v_nxt = (vga.vcount == V_LAST) ? '0 : vga.vcount + 10'd1;
    else
      v_nxt = vga.vcount;

    hsync_nxt  = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    vsync_nxt  = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
    active_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    at_origin  = (h_nxt == '0) && (v_nxt == '0);
    at_vblank  = (h_nxt == '0) && (v_nxt == V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Park at the last position of the frame so the first advance lands on
      // (0,0) and the sync/active decode stays consistent while in reset.
      vga.hcount       <= H_LAST;
      vga.vcount       <= V_LAST;
      vga.hsync        <= 1'b1;
      vga.vsync        <= 1'b1;
      vga.active_video <= 1'b0;
      vga.frame_start  <= 1'b0;
      vga.vblank_start <= 1'b0;
      vga.frame_count  <= '0;
    end else if (vga.pix_en) begin
      vga.hcount       <= h_nxt;
      vga.vcount       <= v_nxt;
      vga.hsync        <= hsync_nxt;
      vga.vsync        <= vsync_nxt;
      vga.active_video <= active_nxt;
      vga.frame_start  <= at_origin;
      vga.vblank_start <= at_vblank;
      if (at_origin)
        vga.frame_count <= vga.frame_count + 16'd1;
    end else begin
      vga.frame_start  <= 1'b0;
      vga.vblank_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster line timing, a scaled-down raster for
// frame-level behaviour, and a 1x1 raster for frame_count wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_f;
  logic rst_s;
  logic rst_t;
  bit   tiny_done = 1'b0;

  int checks = 0;
  int errors = 0;

  vga_timing_gen_if fif ();
  vga_timing_gen_if sif ();
  vga_timing_gen_if tif ();

  vga_timing_gen u_full (
    .clk     (clk),
    .reset_n (rst_f),
    .vga     (fif)
  );

  // 25 clocks/line, 17 lines/frame: hsync low h=18..21, vsync low v=12..13
  vga_timing_gen #(
    .H_ACTIVE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
    .V_ACTIVE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
  ) u_small (
    .clk     (clk),
    .reset_n (rst_s),
    .vga     (sif)
  );

  vga_timing_gen #(
    .H_ACTIVE (1), .H_FRONT (0), .H_SYNC (0), .H_BACK (0),
    .V_ACTIVE (1), .V_FRONT (0), .V_SYNC (0), .V_BACK (0)
  ) u_tiny (
    .clk     (clk),
    .reset_n (rst_t),
    .vga     (tif)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // a = number of advances since reset release (a>=1)
  task automatic chk_small(input int unsigned a, input bit advanced);
    int unsigned p, h, v;
    p = (a - 1) % 425;
    h = p % 25;
    v = p / 25;
    check_val("s_h",   32'(sif.hcount), h);
    check_val("s_v",   32'(sif.vcount), v);
    check_val("s_hs",  32'(sif.hsync), 32'((h >= 18 && h < 22) ? 0 : 1));
    check_val("s_vs",  32'(sif.vsync), 32'((v == 12 || v == 13) ? 0 : 1));
    check_val("s_av",  32'(sif.active_video), 32'(h < 16 && v < 10));
    check_val("s_fs",  32'(sif.frame_start), 32'(advanced && p == 0));
    check_val("s_vbs", 32'(sif.vblank_start), 32'(advanced && p == 250));
    check_val("s_fc",  32'(sif.frame_count), (a + 424) / 425);
    check_val("s_inv", 32'((!sif.hsync || !sif.vsync) && sif.active_video), 0);
  endtask

  task automatic chk_small_reset();
    check_val("sr_h",   32'(sif.hcount), 24);
    check_val("sr_v",   32'(sif.vcount), 16);
    check_val("sr_hs",  32'(sif.hsync), 1);
    check_val("sr_vs",  32'(sif.vsync), 1);
    check_val("sr_av",  32'(sif.active_video), 0);
    check_val("sr_fs",  32'(sif.frame_start), 0);
    check_val("sr_vbs", 32'(sif.vblank_start), 0);
    check_val("sr_fc",  32'(sif.frame_count), 0);
  endtask

  initial begin
    int unsigned a;
    int  hs_run;
    int  vs_run;
    logic prev_hs;
    logic prev_vs;

    fif.pix_en = 1'b1;
    sif.pix_en = 1'b1;
    rst_f = 1'b0;
    rst_s = 1'b0;

    repeat (3) begin
      tick();
      check_val("fr_h",   32'(fif.hcount), 799);
      check_val("fr_v",   32'(fif.vcount), 524);
      check_val("fr_hs",  32'(fif.hsync), 1);
      check_val("fr_vs",  32'(fif.vsync), 1);
      check_val("fr_av",  32'(fif.active_video), 0);
      check_val("fr_fs",  32'(fif.frame_start), 0);
      check_val("fr_vbs", 32'(fif.vblank_start), 0);
      check_val("fr_fc",  32'(fif.frame_count), 0);
    end

    rst_f = 1'b1;
    tick();
    check_val("f1_h",  32'(fif.hcount), 0);
    check_val("f1_v",  32'(fif.vcount), 0);
    check_val("f1_av", 32'(fif.active_video), 1);
    check_val("f1_fs", 32'(fif.frame_start), 1);
    check_val("f1_fc", 32'(fif.frame_count), 1);
    check_val("f1_hs", 32'(fif.hsync), 1);
    check_val("f1_vs", 32'(fif.vsync), 1);

    for (int k = 1; k < 800; k++) begin
      tick();
      check_val("fl_h",  32'(fif.hcount), 32'(k));
      check_val("fl_v",  32'(fif.vcount), 0);
      check_val("fl_hs", 32'(fif.hsync), 32'((k >= 656 && k < 752) ? 0 : 1));
      check_val("fl_av", 32'(fif.active_video), 32'(k < 640));
      check_val("fl_fs", 32'(fif.frame_start), 0);
    end
    tick();
    check_val("fw_h",  32'(fif.hcount), 0);
    check_val("fw_v",  32'(fif.vcount), 1);
    check_val("fw_av", 32'(fif.active_video), 1);
    check_val("fw_fs", 32'(fif.frame_start), 0);

    // Scaled raster: two full frames after release
    chk_small_reset();
    rst_s   = 1'b1;
    a       = 0;
    hs_run  = 0;
    vs_run  = 0;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    for (int n = 1; n <= 850; n++) begin
      tick();
      a++;
      chk_small(a, 1'b1);
      if (!sif.hsync) hs_run++;
      else if (!prev_hs) begin
        check_val("s_hs_w", hs_run, 4);
        hs_run = 0;
      end
      if (prev_vs && !sif.vsync) begin
        check_val("s_vs_fall_h", 32'(sif.hcount), 0);
        check_val("s_vs_fall_v", 32'(sif.vcount), 12);
      end
      if (!sif.vsync) vs_run++;
      else if (!prev_vs) begin
        check_val("s_vs_w", vs_run, 50);
        vs_run = 0;
      end
      prev_hs = sif.hsync;
      prev_vs = sif.vsync;
    end
    check_val("s_fc2", 32'(sif.frame_count), 2);

    // Enable toggling: only odd clocks advance
    for (int j = 0; j < 2000; j++) begin
      sif.pix_en = (j % 2) == 1;
      tick();
      if (sif.pix_en) a++;
      chk_small(a, sif.pix_en);
    end

    // Move to (10,5), then reset mid-frame
    sif.pix_en = 1'b1;
    for (int n = 0; n < 425 && ((a - 1) % 425) != 135; n++) begin
      tick();
      a++;
      chk_small(a, 1'b1);
    end
    check_val("s_pre_h", 32'(sif.hcount), 10);
    check_val("s_pre_v", 32'(sif.vcount), 5);
    rst_s = 1'b0;
    repeat (3) begin
      tick();
      chk_small_reset();
    end
    rst_s = 1'b1;
    tick();
    a = 1;
    chk_small(a, 1'b1);
    sif.pix_en = 1'b0;
    repeat (2) begin
      tick();
      chk_small(a, 1'b0);
    end

    for (int i = 0; i < 70000 && !tiny_done; i++) tick();
    check_val("tiny_done", 32'(tiny_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // 1x1 raster: every advance is a frame start, so frame_count wraps quickly
  initial begin
    tif.pix_en = 1'b1;
    rst_t = 1'b0;
    tick();
    tick();
    check_val("t_rst_fc", 32'(tif.frame_count), 0);
    rst_t = 1'b1;
    for (int n = 1; n <= 65536; n++) begin
      tick();
      if (n == 1) begin
        check_val("t1_fc", 32'(tif.frame_count), 1);
        check_val("t1_fs", 32'(tif.frame_start), 1);
      end
      if (n == 65535) begin
        check_val("tmax_fc", 32'(tif.frame_count), 32'h0000_ffff);
      end
      if (n == 65536) begin
        check_val("twrap_fc", 32'(tif.frame_count), 0);
        check_val("twrap_fs", 32'(tif.frame_start), 1);
        check_val("twrap_h",  32'(tif.hcount), 0);
        check_val("twrap_v",  32'(tif.vcount), 0);
        check_val("twrap_av", 32'(tif.active_video), 1);
      end
    end
    tif.pix_en = 1'b0;
    tick();
    check_val("thold_fs", 32'(tif.frame_start), 0);
    check_val("thold_fc", 32'(tif.frame_count), 0);
    tiny_done = 1'b1;
  end

endmodule
